// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: two-state instruction fetch FSM with PC sequencing, branch/jump/jr redirect,
// acknowledged-instruction counter and sticky misaligned-jr flag.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count,
  output logic        addr_err
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, count_q, count_d;
  logic        err_q, err_d;
  logic        ack_ok, rdy_ok;
  logic [31:0] br_off, next_pc;
  assign ack_ok = (state_q == HOLD) && instr_ack;
  assign rdy_ok = (state_q == FETCH) && imem_ready;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign next_pc = jr ? {jr_target[31:2], 2'b00} :
                   jump ? {pc_plus4[31:28], instr_q[25:0], 2'b00} :
                   (branch && zero) ? pc_plus4 + br_off : pc_plus4;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      count_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = rdy_ok ? HOLD : ack_ok ? FETCH : state_q;
  end
  always_comb begin
    pc_d    = ack_ok ? next_pc : pc_q;
    instr_d = rdy_ok ? imem_rdata : instr_q;
    count_d = ack_ok ? count_q + 32'd1 : count_q;
    err_d   = err_q | (ack_ok && jr && (jr_target[1:0] != 2'b00));
  end
  always_comb begin
    imem_req    = (state_q == FETCH) && !reset;
    imem_addr   = pc_q;
    instr_valid = (state_q == HOLD);
    instr       = instr_q;
    pc          = pc_q;
    instr_count = count_q;
    addr_err    = err_q;
  end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; bits [1:0] are zero.
REQ-002 Ports, in order (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous reset, active-high.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  word-aligned fetch address.
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word from memory.
- instr  out  32  held instruction, fed to the decode/control stage.
- instr_valid  out  1  instr holds a fetched, unconsumed instruction.
- instr_ack  in  1  downstream consumed instr; resolve inputs valid this cycle.
- branch  in  1  beq decoded.
- zero  in  1  ALU zero flag.
- jump  in  1  j or jal decoded.
- jr  in  1  jr decoded.
- jr_target  in  32  rs register value.
- pc  out  32  PC of the current instruction.
- pc_plus4  out  32  pc + 4, combinational; the jal return address.
- instr_count  out  32  count of acknowledged instructions.
- addr_err  out  1  sticky misaligned-jr flag.

Function
REQ-003 The FSM SHALL have two states: FETCH and HOLD.
REQ-004 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; otherwise imem_req SHALL be 0 and imem_addr SHALL hold pc.
REQ-005 FETCH with imem_ready=1 SHALL register imem_rdata into instr, set instr_valid=1 and go to HOLD on the next edge; with imem_ready=0 the FSM SHALL remain in FETCH and keep requesting indefinitely.
REQ-006 HOLD SHALL keep instr and instr_valid=1 stable until instr_ack=1; on that edge it SHALL load the next PC, clear instr_valid and return to FETCH.
REQ-007 instr_ack in FETCH SHALL be ignored, and imem_ready in HOLD SHALL be ignored.
REQ-008 Next-PC priority, evaluated only on ack:
- jr=1: {jr_target[31:2],2'b00}.
- else jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
- else branch=1 and zero=1: pc_plus4 + (sign-extended instr[15:0] << 2).
- else: pc_plus4.
REQ-009 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 SHALL wrap to 0.
REQ-010 Minimum instruction period SHALL be 2 cycles: imem_ready in FETCH at cycle n gives instr_valid at n+1; ack at n+1 gives imem_req for the new PC at n+2.
REQ-011 instr_count SHALL increment by 1 on each accepted ack and wrap from 32'hFFFF_FFFF to 0.
REQ-012 addr_err SHALL set on an accepted ack with jr=1 and jr_target[1:0]!=0, and SHALL stay set until reset.
REQ-013 Simultaneous jr, jump and branch inputs SHALL resolve by REQ-008 priority only; no error is flagged.

Reset
REQ-014 With reset=1 at an edge: pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, instr_count=0, addr_err=0. Reset SHALL override imem_ready and instr_ack in the same cycle.
REQ-015 During reset, imem_req SHALL be 0. The first request SHALL appear in the first cycle after reset deasserts.
REQ-016 Reset in HOLD or FETCH SHALL discard the held instruction and any in-flight ready with no side effects.

Verification
REQ-017 Sequential: reset, memory ready after 3 cycles with 32'h0000_0020, ack immediately -> instr=32'h20, pc steps 0 -> 4, instr_count=1, imem_req low exactly 1 cycle.
REQ-018 Branch taken: pc=8, instr=32'h1000_FFFE, branch=1, zero=1, ack -> pc=32'h0000_0004. Same with zero=0 -> pc=12.
REQ-019 jal: pc=32'h4000_0010, instr=32'h0C00_0100, jump=1, ack -> pc=32'h4000_0400; pc_plus4=32'h4000_0014 during HOLD.
REQ-020 jr priority plus misaligned target: jr=1, jump=1, branch=1, zero=1, jr_target=32'h0000_1003 -> pc=32'h0000_1000, addr_err=1 and stays 1 across 5 later acks.
REQ-021 Stall and reset mid-operation: hold ack low 10 cycles -> instr stable and instr_valid=1 throughout; assert reset in HOLD with ack=1 -> pc=RESET_PC, instr_valid=0, instr_count=0, with no count increment.
REQ-022 Wrap: pc=32'hFFFF_FFFC, sequential ack -> pc=0; instr_count preset via 2^32-1 acks (or forced) -> next ack gives 0.
